spell_mem_arbiter: RTL and testbench

//  Shares the single spell_mem_dff port between two requesters: r0 = spell core
//  (fetch/fetch-data/store), r1 = Wishbone host/debug path. Grants one whole

---
 rtl/spell_mem_arbiter_pkg.sv | 18 +
 rtl/spell_mem_arbiter_if.sv | 43 ++++
 rtl/spell_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_spell_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spell_mem_arbiter_pkg.sv
// Shared types and constants for the spell memory arbiter: memory-type codes
// seen on the bus and the arbiter FSM state encoding.
package spell_mem_arbiter_pkg;

  // Memory-type encodings carried on rN_type / m_type
  localparam logic [1:0] MEMTYPE_CODE  = 2'd0;
  localparam logic [1:0] MEMTYPE_DATA  = 2'd1;
  localparam logic [1:0] MEMTYPE_STACK = 2'd2;
  localparam logic [1:0] MEMTYPE_IO    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/spell_mem_arbiter_if.sv
// Bundle of both requester ports and the memory port around the arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface spell_mem_arbiter_if;
  logic       r0_select,     r1_select;
  logic [7:0] r0_addr,       r1_addr;
  logic [7:0] r0_data_in,    r1_data_in;
  logic [1:0] r0_type,       r1_type;
  logic       r0_write,      r1_write;
  logic [7:0] r0_data_out,   r1_data_out;
  logic       r0_data_ready, r1_data_ready;
  logic       r0_error,      r1_error;

  logic       m_select;
  logic [7:0] m_addr;
  logic [7:0] m_data_in;
  logic [1:0] m_type;
  logic       m_write;
  logic [7:0] m_data_out;
  logic       m_data_ready;

  logic       grant;
  logic       busy;

  modport slave (
    input  r0_select, r0_addr, r0_data_in, r0_type, r0_write,
    input  r1_select, r1_addr, r1_data_in, r1_type, r1_write,
    output r0_data_out, r0_data_ready, r0_error,
    output r1_data_out, r1_data_ready, r1_error,
    output m_select, m_addr, m_data_in, m_type, m_write,
    input  m_data_out, m_data_ready,
    output grant, busy
  );

  modport master (
    output r0_select, r0_addr, r0_data_in, r0_type, r0_write,
    output r1_select, r1_addr, r1_data_in, r1_type, r1_write,
    input  r0_data_out, r0_data_ready, r0_error,
    input  r1_data_out, r1_data_ready, r1_error,
    input  m_select, m_addr, m_data_in, m_type, m_write,
    output m_data_out, m_data_ready,
    input  grant, busy
  );
endinterface

// File: rtl/spell_mem_arbiter.sv
// Two-requester arbiter in front of spell_mem_dff: one whole transaction per
// grant, owner-steered completion and a forced error completion on timeout.
module spell_mem_arbiter
  import spell_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input logic                clock,
  input logic                reset,
  spell_mem_arbiter_if.slave bus
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t  state_reg,     state_next;
  logic        grant_reg,     grant_next;
  logic        rr_reg,        rr_next;
  logic        m_select_reg,  m_select_next;
  logic        m_write_reg,   m_write_next;
  logic [7:0]  m_addr_reg,    m_addr_next;
  logic [7:0]  m_data_in_reg, m_data_in_next;
  logic [1:0]  m_type_reg,    m_type_next;
  logic [15:0] count_reg,     count_next;
  logic        pick;
  logic        timeout_hit;

  // An ack arriving in the final timeout cycle wins over the forced error.
  assign timeout_hit = (state_reg == ST_BUSY) && (count_reg == TIMEOUT_LAST)
                       && !bus.m_data_ready;

  always_comb begin
    if (bus.r0_select && bus.r1_select) pick = FIXED_PRIORITY ? 1'b0 : rr_reg;
    else                                pick = bus.r1_select;
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_next        = rr_reg;
    m_select_next  = m_select_reg;
    m_write_next   = m_write_reg;
    m_addr_next    = m_addr_reg;
    m_data_in_next = m_data_in_reg;
    m_type_next    = m_type_reg;
    count_next     = count_reg;
    case (state_reg)
      ST_IDLE: begin
        count_next = '0;
        if (bus.r0_select || bus.r1_select) begin
          grant_next     = pick;
          m_addr_next    = pick ? bus.r1_addr    : bus.r0_addr;
          m_data_in_next = pick ? bus.r1_data_in : bus.r0_data_in;
          m_type_next    = pick ? bus.r1_type    : bus.r0_type;
          m_write_next   = pick ? bus.r1_write   : bus.r0_write;
          state_next     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        m_select_next = 1'b1;
        state_next    = ST_BUSY;
      end
      ST_BUSY: begin
        count_next = count_reg + 16'd1;
        if (bus.m_data_ready) begin
          m_select_next = 1'b0;
          m_write_next  = 1'b0;
          rr_next       = ~grant_reg;
          state_next    = ST_RELEASE;
        end else if (timeout_hit) begin
          m_select_next = 1'b0;
          state_next    = ST_RELEASE;
        end
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= 1'b0;
      rr_reg        <= 1'b0;
      m_select_reg  <= 1'b0;
      m_write_reg   <= 1'b0;
      m_addr_reg    <= '0;
      m_data_in_reg <= '0;
      m_type_reg    <= '0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_reg        <= rr_next;
      m_select_reg  <= m_select_next;
      m_write_reg   <= m_write_next;
      m_addr_reg    <= m_addr_next;
      m_data_in_reg <= m_data_in_next;
      m_type_reg    <= m_type_next;
      count_reg     <= count_next;
    end
  end

  // Return path is combinational so the owner sees the ack in the same cycle.
  always_comb begin
    bus.r0_data_ready = 1'b0;
    bus.r0_error      = 1'b0;
    bus.r0_data_out   = '0;
    bus.r1_data_ready = 1'b0;
    bus.r1_error      = 1'b0;
    bus.r1_data_out   = '0;
    if (state_reg == ST_BUSY) begin
      if (grant_reg) begin
        bus.r1_data_ready = bus.m_data_ready | timeout_hit;
        bus.r1_error      = timeout_hit;
        bus.r1_data_out   = timeout_hit ? 8'hFF : bus.m_data_out;
      end else begin
        bus.r0_data_ready = bus.m_data_ready | timeout_hit;
        bus.r0_error      = timeout_hit;
        bus.r0_data_out   = timeout_hit ? 8'hFF : bus.m_data_out;
      end
    end
  end

  assign bus.m_select  = m_select_reg;
  assign bus.m_write   = m_write_reg;
  assign bus.m_addr    = m_addr_reg;
  assign bus.m_data_in = m_data_in_reg;
  assign bus.m_type    = m_type_reg;
  assign bus.grant     = grant_reg;
  assign bus.busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Directed bench: round-robin instance plus a fixed-priority instance, both
// with an 8-cycle timeout; memory side is driven by hand.
module tb_spell_mem_arbiter;
  import spell_mem_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  spell_mem_arbiter_if bus_rr ();
  spell_mem_arbiter_if bus_fp ();

  spell_mem_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIORITY(1'b0)) dut_rr (
    .clock (clock),
    .reset (reset),
    .bus   (bus_rr.slave)
  );

  spell_mem_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIORITY(1'b1)) dut_fp (
    .clock (clock),
    .reset (reset),
    .bus   (bus_fp.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rr_wait_mselect(input string tag);
    int n = 0;
    while (!bus_rr.m_select && n < 12) begin
      step();
      n++;
    end
    check({tag, "_mselect_seen"}, 32'(bus_rr.m_select), 32'd1);
  endtask

  // One acked round on the round-robin instance with the expected owner.
  task automatic rr_round(input string tag, input logic exp_owner, input logic [7:0] d);
    rr_wait_mselect(tag);
    check({tag, "_grant"}, 32'(bus_rr.grant), 32'(exp_owner));
    bus_rr.m_data_out   = d;
    bus_rr.m_data_ready = 1'b1;
    #1;
    check({tag, "_r0_ready"}, 32'(bus_rr.r0_data_ready), 32'(!exp_owner));
    check({tag, "_r1_ready"}, 32'(bus_rr.r1_data_ready), 32'(exp_owner));
    check({tag, "_owner_data"}, 32'(exp_owner ? bus_rr.r1_data_out : bus_rr.r0_data_out), 32'(d));
    check({tag, "_other_data"}, 32'(exp_owner ? bus_rr.r0_data_out : bus_rr.r1_data_out), 32'd0);
    $display("txn %s owner=r%0d data=%02h", tag, exp_owner, d);
    step();
    bus_rr.m_data_ready = 1'b0;
    bus_rr.m_data_out   = 8'h00;
    #1;
    check({tag, "_strobe_one_cycle"}, 32'({bus_rr.r0_data_ready, bus_rr.r1_data_ready}), 32'd0);
    check({tag, "_mselect_low"}, 32'(bus_rr.m_select), 32'd0);
  endtask

  task automatic fp_round(input string tag, input logic exp_owner, input logic [7:0] d);
    int n = 0;
    while (!bus_fp.m_select && n < 12) begin
      step();
      n++;
    end
    check({tag, "_mselect_seen"}, 32'(bus_fp.m_select), 32'd1);
    check({tag, "_grant"}, 32'(bus_fp.grant), 32'(exp_owner));
    bus_fp.m_data_out   = d;
    bus_fp.m_data_ready = 1'b1;
    #1;
    check({tag, "_ready"}, 32'({bus_fp.r1_data_ready, bus_fp.r0_data_ready}),
          exp_owner ? 32'd2 : 32'd1);
    $display("txn %s owner=r%0d data=%02h", tag, exp_owner, d);
    step();
    bus_fp.m_data_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {bus_rr.r0_select, bus_rr.r1_select, bus_rr.r0_write, bus_rr.r1_write} = '0;
    {bus_rr.r0_addr, bus_rr.r1_addr, bus_rr.r0_data_in, bus_rr.r1_data_in} = '0;
    {bus_rr.r0_type, bus_rr.r1_type, bus_rr.m_data_out, bus_rr.m_data_ready} = '0;
    {bus_fp.r0_select, bus_fp.r1_select, bus_fp.r0_write, bus_fp.r1_write} = '0;
    {bus_fp.r0_addr, bus_fp.r1_addr, bus_fp.r0_data_in, bus_fp.r1_data_in} = '0;
    {bus_fp.r0_type, bus_fp.r1_type, bus_fp.m_data_out, bus_fp.m_data_ready} = '0;
    step();
    step();
    reset = 1'b0;

    check("rst_mselect", 32'(bus_rr.m_select), 32'd0);
    check("rst_busy", 32'(bus_rr.busy), 32'd0);
    check("rst_grant", 32'(bus_rr.grant), 32'd0);
    check("rst_m_fields", 32'({bus_rr.m_addr, bus_rr.m_data_in, bus_rr.m_type, bus_rr.m_write}), 32'd0);
    check("rst_ready", 32'({bus_rr.r0_data_ready, bus_rr.r1_data_ready}), 32'd0);

    // r0 read of Code at 8'h10, ack three cycles into BUSY
    bus_rr.r0_select = 1'b1;
    bus_rr.r0_addr   = 8'h10;
    bus_rr.r0_type   = MEMTYPE_CODE;
    step();
    check("rd_grant_busy", 32'(bus_rr.busy), 32'd1);
    check("rd_grant_mselect", 32'(bus_rr.m_select), 32'd0);
    check("rd_m_addr", 32'(bus_rr.m_addr), 32'h10);
    step();
    check("rd_latency2_mselect", 32'(bus_rr.m_select), 32'd1);
    check("rd_m_write", 32'(bus_rr.m_write), 32'd0);
    step();
    check("rd_no_early_ready", 32'(bus_rr.r0_data_ready), 32'd0);
    step();
    bus_rr.m_data_out   = 8'h2A;
    bus_rr.m_data_ready = 1'b1;
    #1;
    check("rd_r0_ready", 32'(bus_rr.r0_data_ready), 32'd1);
    check("rd_r0_data", 32'(bus_rr.r0_data_out), 32'h2A);
    check("rd_r1_quiet", 32'({bus_rr.r1_data_ready, bus_rr.r1_error, bus_rr.r1_data_out}), 32'd0);
    check("rd_no_error", 32'(bus_rr.r0_error), 32'd0);
    $display("txn rd owner=r0 addr=10 data=2a");
    step();
    bus_rr.m_data_ready = 1'b0;
    bus_rr.r0_select    = 1'b0;
    #1;
    check("rd_release_mselect", 32'(bus_rr.m_select), 32'd0);
    check("rd_release_busy", 32'(bus_rr.busy), 32'd1);
    check("rd_release_ready", 32'(bus_rr.r0_data_ready), 32'd0);
    step();
    check("rd_idle_busy", 32'(bus_rr.busy), 32'd0);

    // Round-robin from a fresh pointer, both held for three rounds
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_rr.r0_select = 1'b1;
    bus_rr.r1_select = 1'b1;
    rr_round("rr1", 1'b0, 8'h41);
    rr_round("rr2", 1'b1, 8'h42);
    rr_round("rr3", 1'b0, 8'h43);
    bus_rr.r0_select = 1'b0;
    bus_rr.r1_select = 1'b0;
    step();
    step();

    // Fixed priority: r0 keeps winning until it drops select
    bus_fp.r0_select = 1'b1;
    bus_fp.r1_select = 1'b1;
    fp_round("fp1", 1'b0, 8'h51);
    fp_round("fp2", 1'b0, 8'h52);
    bus_fp.r0_select = 1'b0;
    fp_round("fp3", 1'b1, 8'h53);
    bus_fp.r1_select = 1'b0;

    // Timeout: r1 never acked, error completion on the eighth BUSY cycle
    bus_rr.r1_select = 1'b1;
    bus_rr.r1_addr   = 8'h33;
    bus_rr.r1_write  = 1'b0;
    rr_wait_mselect("to");
    for (int i = 1; i < 8; i++) begin
      check("to_no_early_ready", 32'(bus_rr.r1_data_ready), 32'd0);
      step();
    end
    check("to_ready", 32'(bus_rr.r1_data_ready), 32'd1);
    check("to_error", 32'(bus_rr.r1_error), 32'd1);
    check("to_data_ff", 32'(bus_rr.r1_data_out), 32'hFF);
    check("to_r0_quiet", 32'({bus_rr.r0_data_ready, bus_rr.r0_error}), 32'd0);
    $display("txn to owner=r1 addr=33 timeout");
    step();
    bus_rr.r1_select = 1'b0;
    check("to_release_mselect", 32'(bus_rr.m_select), 32'd0);
    check("to_release_ready", 32'(bus_rr.r1_data_ready), 32'd0);
    step();
    check("to_idle", 32'(bus_rr.busy), 32'd0);

    // Ack in the final timeout cycle is a normal completion
    bus_rr.r0_select = 1'b1;
    rr_wait_mselect("tb");
    for (int i = 1; i < 8; i++) step();
    bus_rr.m_data_out   = 8'h77;
    bus_rr.m_data_ready = 1'b1;
    #1;
    check("tb_ready", 32'(bus_rr.r0_data_ready), 32'd1);
    check("tb_no_error", 32'(bus_rr.r0_error), 32'd0);
    check("tb_data", 32'(bus_rr.r0_data_out), 32'h77);
    $display("txn tb owner=r0 ack on last cycle data=77");
    step();
    bus_rr.m_data_ready = 1'b0;
    bus_rr.r0_select    = 1'b0;
    step();

    // r1 write: latched fields hold even if the requester changes them
    bus_rr.r1_select  = 1'b1;
    bus_rr.r1_addr    = 8'h05;
    bus_rr.r1_data_in = 8'hC3;
    bus_rr.r1_type    = MEMTYPE_DATA;
    bus_rr.r1_write   = 1'b1;
    rr_wait_mselect("wr");
    bus_rr.r1_addr    = 8'h99;
    bus_rr.r1_data_in = 8'h00;
    bus_rr.r1_type    = MEMTYPE_IO;
    bus_rr.r1_select  = 1'b0;
    step();
    step();
    check("wr_m_write", 32'(bus_rr.m_write), 32'd1);
    check("wr_m_addr", 32'(bus_rr.m_addr), 32'h05);
    check("wr_m_data_in", 32'(bus_rr.m_data_in), 32'hC3);
    check("wr_m_type", 32'(bus_rr.m_type), 32'(MEMTYPE_DATA));
    bus_rr.m_data_ready = 1'b1;
    #1;
    check("wr_r1_ready_after_drop", 32'(bus_rr.r1_data_ready), 32'd1);
    $display("txn wr owner=r1 addr=05 data=c3");
    step();
    bus_rr.m_data_ready = 1'b0;
    check("wr_m_write_cleared", 32'(bus_rr.m_write), 32'd0);
    step();

    // Stray ack while idle is ignored
    bus_rr.m_data_ready = 1'b1;
    #1;
    check("stray_ack", 32'({bus_rr.r0_data_ready, bus_rr.r1_data_ready}), 32'd0);
    step();
    bus_rr.m_data_ready = 1'b0;

    // Reset mid-BUSY aborts without a strobe
    bus_rr.r0_select = 1'b1;
    rr_wait_mselect("rst");
    step();
    reset = 1'b1;
    step();
    check("rst_mid_mselect", 32'(bus_rr.m_select), 32'd0);
    check("rst_mid_busy", 32'(bus_rr.busy), 32'd0);
    bus_rr.m_data_ready = 1'b1;
    #1;
    check("rst_mid_no_ready", 32'(bus_rr.r0_data_ready), 32'd0);
    bus_rr.m_data_ready = 1'b0;
    bus_rr.r0_select    = 1'b0;
    reset = 1'b0;
    $display("txn rst owner=r0 aborted");
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
